// File: rtl/npu_pkg.sv
// Shared types and sizing helpers for the NPU stream loader.
// Region counts below describe the default two-layer configuration.
package npu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_W1 = 3'd1,
        LD_B1 = 3'd2,
        LD_W2 = 3'd3,
        LD_B2 = 3'd4,
        LD_IN = 3'd5,
        DONE  = 3'd6
    } loader_state_t;

    localparam int DEF_IN_N       = 2;
    localparam int DEF_HIDDEN_N   = 3;
    localparam int DEF_OUT_N      = 2;
    localparam int DEF_DATA_WIDTH = 8;

    localparam int DEF_W1_WORDS  = DEF_HIDDEN_N * DEF_IN_N;
    localparam int DEF_B1_WORDS  = DEF_HIDDEN_N;
    localparam int DEF_W2_WORDS  = DEF_OUT_N * DEF_HIDDEN_N;
    localparam int DEF_B2_WORDS  = DEF_OUT_N;
    localparam int DEF_IN_WORDS  = DEF_IN_N;
    localparam int DEF_ALL_WORDS = DEF_W1_WORDS + DEF_B1_WORDS + DEF_W2_WORDS
                                 + DEF_B2_WORDS + DEF_IN_WORDS;

    // Index width wide enough for the largest region, never below one bit.
    function automatic int idx_width(input int w1, input int b1, input int w2,
                                     input int b2, input int inw);
        int mx;
        mx = w1;
        if (b1 > mx)  mx = b1;
        if (w2 > mx)  mx = w2;
        if (b2 > mx)  mx = b2;
        if (inw > mx) mx = inw;
        return (mx < 2) ? 1 : $clog2(mx);
    endfunction

endpackage

// File: rtl/npu_region_reg.sv
// Word-addressed packed register; word 0 sits in the least significant bits.
module npu_region_reg #(
    parameter int WORDS      = 1,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we,
    input  logic [IDX_W-1:0]            idx,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [WORDS*DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < WORDS; i++) begin
                if (idx == IDX_W'(i)) mem[i] <= wdata;
            end
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_pack
        assign data[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

endmodule

// File: rtl/npu_stream_loader.sv
// Assembles NPU parameter and input buses from a word-serial stream.
//
// state | meaning
// IDLE  | waiting for a load command (cmd_ready=1)
// LD_W1 | receiving layer-1 weights
// LD_B1 | receiving layer-1 biases
// LD_W2 | receiving layer-2 weights
// LD_B2 | receiving layer-2 biases
// LD_IN | receiving the input vector; final word must carry s_last
// DONE  | set presented on out_valid until out_ready
module npu_stream_loader
    import npu_pkg::*;
#(
    parameter int IN_N       = DEF_IN_N,
    parameter int HIDDEN_N   = DEF_HIDDEN_N,
    parameter int OUT_N      = DEF_OUT_N,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_input_only,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [DATA_WIDTH-1:0]                s_data,
    input  logic                                 s_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 params_loaded,
    output logic                                 err,
    output logic [IN_N*DATA_WIDTH-1:0]           in_vec,
    output logic [HIDDEN_N*IN_N*DATA_WIDTH-1:0]  weights1,
    output logic [HIDDEN_N*DATA_WIDTH-1:0]       biases1,
    output logic [OUT_N*HIDDEN_N*DATA_WIDTH-1:0] weights2,
    output logic [OUT_N*DATA_WIDTH-1:0]          biases2
);

    localparam int W1_WORDS = HIDDEN_N * IN_N;
    localparam int B1_WORDS = HIDDEN_N;
    localparam int W2_WORDS = OUT_N * HIDDEN_N;
    localparam int B2_WORDS = OUT_N;
    localparam int IN_WORDS = IN_N;
    localparam int IDX_W    = idx_width(W1_WORDS, B1_WORDS, W2_WORDS, B2_WORDS, IN_WORDS);

    loader_state_t    state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx, last_idx;
    logic             params_loaded_nx;
    logic             full_load, full_load_nx;
    logic             err_nx;
    logic             armed;
    logic             s_take, region_end, final_word;

    // armed keeps cmd_ready low while reset is held and until the first clock after release.
    assign cmd_ready  = armed && (state == IDLE);
    assign s_ready    = (state == LD_W1) || (state == LD_B1) || (state == LD_W2)
                     || (state == LD_B2) || (state == LD_IN);
    assign out_valid  = (state == DONE);
    assign s_take     = s_valid && s_ready;

    always_comb begin
        last_idx = '0;
        case (state)
            LD_W1:   last_idx = IDX_W'(W1_WORDS - 1);
            LD_B1:   last_idx = IDX_W'(B1_WORDS - 1);
            LD_W2:   last_idx = IDX_W'(W2_WORDS - 1);
            LD_B2:   last_idx = IDX_W'(B2_WORDS - 1);
            LD_IN:   last_idx = IDX_W'(IN_WORDS - 1);
            default: last_idx = '0;
        endcase
    end

    assign region_end = (idx == last_idx);
    assign final_word = (state == LD_IN) && region_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            params_loaded <= 1'b0;
            full_load     <= 1'b0;
            err           <= 1'b0;
            armed         <= 1'b0;
        end else begin
            state         <= state_nx;
            idx           <= idx_nx;
            params_loaded <= params_loaded_nx;
            full_load     <= full_load_nx;
            err           <= err_nx;
            armed         <= 1'b1;
        end
    end

    always_comb begin
        state_nx         = state;
        idx_nx           = idx;
        params_loaded_nx = params_loaded;
        full_load_nx     = full_load;
        err_nx           = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    idx_nx = '0;
                    if (!cmd_input_only) begin
                        state_nx         = LD_W1;
                        params_loaded_nx = 1'b0;
                        full_load_nx     = 1'b1;
                    end else if (params_loaded) begin
                        state_nx     = LD_IN;
                        full_load_nx = 1'b0;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            LD_W1, LD_B1, LD_W2, LD_B2, LD_IN: begin
                if (s_take) begin
                    idx_nx = region_end ? '0 : idx + IDX_W'(1);
                    // A misplaced or missing s_last aborts; the word itself is already written.
                    if (s_last != final_word) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                        idx_nx   = '0;
                    end else if (region_end) begin
                        case (state)
                            LD_W1:   state_nx = LD_B1;
                            LD_B1:   state_nx = LD_W2;
                            LD_W2:   state_nx = LD_B2;
                            LD_B2:   state_nx = LD_IN;
                            default: begin
                                state_nx = DONE;
                                if (full_load) params_loaded_nx = 1'b1;
                            end
                        endcase
                    end
                end
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    npu_region_reg #(.WORDS(W1_WORDS), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_w1 (
        .clk(clk), .rst_n(rst_n), .we(s_take && (state == LD_W1)),
        .idx(idx), .wdata(s_data), .data(weights1));

    npu_region_reg #(.WORDS(B1_WORDS), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_b1 (
        .clk(clk), .rst_n(rst_n), .we(s_take && (state == LD_B1)),
        .idx(idx), .wdata(s_data), .data(biases1));

    npu_region_reg #(.WORDS(W2_WORDS), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_w2 (
        .clk(clk), .rst_n(rst_n), .we(s_take && (state == LD_W2)),
        .idx(idx), .wdata(s_data), .data(weights2));

    npu_region_reg #(.WORDS(B2_WORDS), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_b2 (
        .clk(clk), .rst_n(rst_n), .we(s_take && (state == LD_B2)),
        .idx(idx), .wdata(s_data), .data(biases2));

    npu_region_reg #(.WORDS(IN_WORDS), .DATA_WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_in (
        .clk(clk), .rst_n(rst_n), .we(s_take && (state == LD_IN)),
        .idx(idx), .wdata(s_data), .data(in_vec));

endmodule

// File: tb/tb_npu_stream_loader.sv
// Directed bench for npu_stream_loader with IN_N=2, HIDDEN_N=3, OUT_N=2, 8-bit words.
module tb_npu_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_input_only = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        params_loaded;
    logic        err;
    logic [15:0] in_vec;
    logic [47:0] weights1;
    logic [23:0] biases1;
    logic [47:0] weights2;
    logic [15:0] biases2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [7:0] words [0:31];

    npu_stream_loader #(.IN_N(2), .HIDDEN_N(3), .OUT_N(2), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_input_only(cmd_input_only),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .params_loaded(params_loaded), .err(err),
        .in_vec(in_vec), .weights1(weights1), .biases1(biases1),
        .weights2(weights2), .biases2(biases2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issues a command and streams n words from words[]; s_last is placed on word last_at.
    // Stops on out_valid, err, or after abort_at words have been accepted.
    task automatic load(input bit io, input int n, input int last_at, input bit gaps,
                        input int abort_at, output int lat, output int taken);
        int  t_acc;
        bit  take;
        lat   = -1;
        t_acc = -1;
        taken = 0;
        cmd_input_only = io;
        cmd_valid      = 1'b1;
        s_data  = words[0];
        s_last  = (last_at == 1);
        s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            if (cmd_valid && cmd_ready) t_acc = cyc;
            if (out_valid) begin
                if (t_acc >= 0) lat = cyc - t_acc;
                break;
            end
            take = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (t_acc >= 0) cmd_valid = 1'b0;
            if (take) taken++;
            if (err || taken == abort_at) break;
            if (taken >= n) begin
                s_valid = 1'b0;
            end else begin
                s_data  = words[taken];
                s_last  = (taken + 1 == last_at);
                s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
    endtask

    initial begin
        int lat, taken;

        // Reset state
        #12;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_params", params_loaded, 0);
        check("rst_err", err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        check("cmd_ready_after_rst", cmd_ready, 1);

        // Input-only with no resident parameters
        cmd_valid = 1'b1; cmd_input_only = 1'b1;
        @(posedge clk) #1;
        cmd_valid = 1'b0;
        check("io_noparam_err", err, 1);
        check("io_noparam_idle", cmd_ready, 1);
        check("io_noparam_s_ready", s_ready, 0);
        @(posedge clk) #1;
        check("io_noparam_err_pulse", err, 0);
        check("io_noparam_s_ready2", s_ready, 0);

        // Full load of 1..19
        for (int i = 0; i < 19; i++) words[i] = 8'(i + 1);
        load(1'b0, 19, 19, 1'b0, -1, lat, taken);
        check("full_lat", 64'(lat), 20);
        check("full_w1", weights1, 48'h060504030201);
        check("full_b1", biases1, 24'h090807);
        check("full_w2", weights2, 48'h0F0E0D0C0B0A);
        check("full_b2", biases2, 16'h1110);
        check("full_in", in_vec, 16'h1312);
        check("full_params", params_loaded, 1);

        // Hold in DONE with out_ready low; stray stream word and command must be ignored
        s_valid = 1'b1; s_data = 8'hEE; cmd_valid = 1'b1; cmd_input_only = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_s_ready", s_ready, 0);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_w1", weights1, 48'h060504030201);
            check("hold_in", in_vec, 16'h1312);
        end
        s_valid = 1'b0; cmd_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;
        check("handoff_out_valid", out_valid, 0);
        check("handoff_idle", cmd_ready, 1);
        check("handoff_params", params_loaded, 1);
        check("handoff_w2", weights2, 48'h0F0E0D0C0B0A);

        // Input-only reload
        words[0] = 8'h7F; words[1] = 8'h80;
        load(1'b1, 2, 2, 1'b0, -1, lat, taken);
        check("io_lat", 64'(lat), 3);
        check("io_in", in_vec, 16'h807F);
        check("io_w1", weights1, 48'h060504030201);
        check("io_b1", biases1, 24'h090807);
        check("io_w2", weights2, 48'h0F0E0D0C0B0A);
        check("io_b2", biases2, 16'h1110);
        out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;
        check("io_handoff_idle", cmd_ready, 1);

        // Early s_last on word 10
        for (int i = 0; i < 19; i++) words[i] = 8'(i + 1);
        load(1'b0, 19, 10, 1'b0, -1, lat, taken);
        check("elast_taken", 64'(taken), 10);
        check("elast_err", err, 1);
        check("elast_idle", cmd_ready, 1);
        check("elast_s_ready", s_ready, 0);
        check("elast_params", params_loaded, 0);
        check("elast_w2_word", weights2[7:0], 8'h0A);
        check("elast_no_lat", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk) #1;
        check("elast_err_pulse", err, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("elast_out_valid", out_valid, 0);
        end

        // Reset mid-load with random stream gaps
        for (int i = 0; i < 19; i++) words[i] = 8'(8'h60 + i);
        load(1'b0, 19, 19, 1'b1, 7, lat, taken);
        check("abort_taken", 64'(taken), 7);
        check("abort_w1_pre", weights1, 48'h656463626160);
        rst_n = 1'b0;
        #1;
        check("abort_cmd_ready", cmd_ready, 0);
        check("abort_s_ready", s_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_params", params_loaded, 0);
        check("abort_err", err, 0);
        check("abort_w1", weights1, 0);
        check("abort_b1", biases1, 0);
        check("abort_w2", weights2, 0);
        check("abort_b2", biases2, 0);
        check("abort_in", in_vec, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        check("abort_cmd_ready_rel", cmd_ready, 1);

        // Full load after reset
        for (int i = 0; i < 19; i++) words[i] = 8'(8'h40 + i);
        load(1'b0, 19, 19, 1'b0, -1, lat, taken);
        check("reload_lat", 64'(lat), 20);
        check("reload_w1", weights1, 48'h454443424140);
        check("reload_b1", biases1, 24'h484746);
        check("reload_w2", weights2, 48'h4E4D4C4B4A49);
        check("reload_b2", biases2, 16'h504F);
        check("reload_in", in_vec, 16'h5251);
        check("reload_params", params_loaded, 1);
        out_ready = 1'b1;
        @(posedge clk) #1;
        out_ready = 1'b0;
        check("reload_handoff", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
